// File: rtl/fetch_pkg.sv
// Shared state encoding and address-alignment helpers for the fetch sequencer.
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    ISSUE  = 3'd2,
    HALTED = 3'd3,
    ERR    = 3'd4
  } fetch_state_t;

  localparam int DEF_INSTR_W = 32;
  localparam int INSTR_BYTES = DEF_INSTR_W / 8;

  // Mask that clears the byte-offset bits inside one instruction word.
  function automatic logic [63:0] align_mask(input int instr_bytes);
    return ~(64'(instr_bytes) - 64'd1);
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Bundle of memory-side and core-side fetch signals; master is the sequencer side.
interface fetch_if #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32
);
  logic [ADDR_W-1:0]  pointer;
  logic               mem_req;
  logic               mem_ack;
  logic [INSTR_W-1:0] instr_in;
  logic [INSTR_W-1:0] instr_out;
  logic               instr_valid;
  logic               core_ready;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_addr;
  logic               halt;
  logic               fetch_err;

  modport master (
    output pointer, mem_req, instr_out, instr_valid, fetch_err,
    input  mem_ack, instr_in, core_ready, redirect_valid, redirect_addr, halt
  );

  modport slave (
    input  pointer, mem_req, instr_out, instr_valid, fetch_err,
    output mem_ack, instr_in, core_ready, redirect_valid, redirect_addr, halt
  );
endinterface

// File: rtl/fetch_timer.sv
// Saturating wait counter; o_expire flags the last enabled cycle before LIMIT is reached.
module fetch_timer #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expire
);
  localparam int CW = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (i_rst || i_clear) begin
      r_count <= '0;
    end else if (i_en && (r_count != CW'(LIMIT))) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign o_expire = i_en && !i_clear && (r_count >= CW'(LIMIT - 1));
endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: single-outstanding req/ack to memory, valid/ready to the core.
// Optional request timeout (ERR state, fetch_err) is built when FETCH_TIMEOUT_EN is defined.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int                ADDR_W       = 32,
  parameter int                INSTR_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter int                TIMEOUT_CYC  = 16
) (
  input  logic     clk,
  input  logic     _reset,
  fetch_if.master  bus
);
  localparam int                STEP      = INSTR_W / 8;
  localparam logic [63:0]       MASK_FULL = align_mask(STEP);
  localparam logic [ADDR_W-1:0] ADDR_MASK = MASK_FULL[ADDR_W-1:0];

  fetch_state_t       r_state, w_state_next;
  logic [ADDR_W-1:0]  r_pointer, w_pointer_next;
  logic [ADDR_W-1:0]  r_redir_addr, w_redir_addr_next;
  logic [INSTR_W-1:0] r_instr_out, w_instr_out_next;
  logic               r_redir_pend, w_redir_pend_next;
  logic [ADDR_W-1:0]  w_redir_target;
  logic               w_timeout;

  assign w_redir_target = bus.redirect_addr & ADDR_MASK;

`ifdef FETCH_TIMEOUT_EN
  // Counter idles at zero outside REQ, so every entry to REQ starts a fresh wait.
  fetch_timer #(.LIMIT(TIMEOUT_CYC)) u_timer (
    .clk      (clk),
    .i_rst    (_reset),
    .i_clear  ((r_state != REQ) || bus.mem_ack),
    .i_en     (r_state == REQ),
    .o_expire (w_timeout)
  );
  assign bus.fetch_err = (r_state == ERR);
`else
  logic w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = ^TIMEOUT_CYC;
  assign w_timeout            = 1'b0;
  assign bus.fetch_err        = 1'b0;
`endif

  always_comb begin
    w_state_next      = r_state;
    w_pointer_next    = r_pointer;
    w_instr_out_next  = r_instr_out;
    w_redir_pend_next = r_redir_pend;
    w_redir_addr_next = r_redir_addr;
    case (r_state)
      IDLE: w_state_next = REQ;
      REQ: begin
        if (bus.mem_ack) begin
          // Data for a redirected request is stale: drop it and re-request at the target.
          if (r_redir_pend || bus.redirect_valid) begin
            w_pointer_next    = bus.redirect_valid ? w_redir_target : r_redir_addr;
            w_redir_pend_next = 1'b0;
          end else begin
            w_instr_out_next = bus.instr_in;
            w_state_next     = ISSUE;
          end
        end else if (w_timeout) begin
          w_state_next      = ERR;
          w_redir_pend_next = 1'b0;
        end else if (bus.redirect_valid) begin
          w_redir_pend_next = 1'b1;
          w_redir_addr_next = w_redir_target;
        end
      end
      ISSUE: begin
        if (bus.redirect_valid) begin
          w_pointer_next = w_redir_target;
          w_state_next   = REQ;
        end else if (bus.core_ready) begin
          w_pointer_next = r_pointer + ADDR_W'(STEP);
          w_state_next   = bus.halt ? HALTED : REQ;
        end
      end
      HALTED, ERR: begin
        if (bus.redirect_valid) begin
          w_pointer_next = w_redir_target;
          w_state_next   = REQ;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (_reset) begin
      r_state      <= IDLE;
      r_pointer    <= RESET_VECTOR;
      r_instr_out  <= '0;
      r_redir_pend <= 1'b0;
      r_redir_addr <= '0;
    end else begin
      r_state      <= w_state_next;
      r_pointer    <= w_pointer_next;
      r_instr_out  <= w_instr_out_next;
      r_redir_pend <= w_redir_pend_next;
      r_redir_addr <= w_redir_addr_next;
    end
  end

  assign bus.pointer     = r_pointer;
  assign bus.mem_req     = (r_state == REQ);
  assign bus.instr_valid = (r_state == ISSUE);
  assign bus.instr_out   = r_instr_out;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus a randomized run
// checked against a transaction-level model of the fetched address stream.
module tb_fetch_sequencer;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  fetch_if #(.ADDR_W(32), .INSTR_W(32)) bus ();

  fetch_sequencer #(
    .ADDR_W(32), .INSTR_W(32), .RESET_VECTOR(32'h0), .TIMEOUT_CYC(4)
  ) dut (
    .clk    (clk),
    ._reset (rst),
    .bus    (bus)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    bus.mem_ack        = 1'b0;
    bus.instr_in       = '0;
    bus.core_ready     = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_addr  = '0;
    bus.halt           = 1'b0;
  endtask

  // Leaves the DUT in IDLE: the next edge moves it into REQ.
  task automatic do_reset;
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    total++; if (bus.pointer !== 32'h0) begin bad++; $display("FAIL reset_pointer: got %h want %h", bus.pointer, 32'h0); end
    total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL reset_mem_req: got %b want 0", bus.mem_req); end
    total++; if (bus.instr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus.instr_valid); end
    total++; if (bus.instr_out !== 32'h0) begin bad++; $display("FAIL reset_instr_out: got %h want 0", bus.instr_out); end
    total++; if (bus.fetch_err !== 1'b0) begin bad++; $display("FAIL reset_fetch_err: got %b want 0", bus.fetch_err); end
    // An ack while IDLE must not complete anything.
    bus.mem_ack  = 1'b1;
    bus.instr_in = 32'hDEAD_BEEF;
    rst = 1'b0;
    total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL idle_no_req: got %b want 0", bus.mem_req); end
    tick();
    bus.mem_ack = 1'b0;
    total++; if (bus.mem_req !== 1'b1) begin bad++; $display("FAIL first_req: got %b want 1", bus.mem_req); end
    total++; if (bus.instr_valid !== 1'b0) begin bad++; $display("FAIL first_req_valid: got %b want 0", bus.instr_valid); end
    tick();
    total++; if (bus.mem_req !== 1'b1) begin bad++; $display("FAIL idle_ack_ignored: mem_req got %b want 1", bus.mem_req); end
    total++; if (bus.instr_valid !== 1'b0) begin bad++; $display("FAIL idle_ack_valid: got %b want 0", bus.instr_valid); end
    $display("test_reset done");
  endtask

  task automatic test_stream;
    logic [31:0] exp;
    do_reset();
    bus.core_ready = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      exp = 32'(4 * k);
      total++; if (bus.mem_req !== 1'b1 || bus.pointer !== exp) begin bad++; $display("FAIL stream_req[%0d]: req=%b ptr=%h want req=1 ptr=%h", k, bus.mem_req, bus.pointer, exp); end
      bus.mem_ack  = 1'b1;
      bus.instr_in = mem_word(exp);
      tick();
      bus.mem_ack = 1'b0;
      total++; if (bus.instr_valid !== 1'b1 || bus.mem_req !== 1'b0) begin bad++; $display("FAIL stream_valid[%0d]: valid=%b req=%b want 1/0", k, bus.instr_valid, bus.mem_req); end
      total++; if (bus.instr_out !== mem_word(exp)) begin bad++; $display("FAIL stream_data[%0d]: got %h want %h", k, bus.instr_out, mem_word(exp)); end
      $display("stream fetch addr=%h word=%h", exp, bus.instr_out);
      tick();
    end
  endtask

  // Ends in ISSUE holding the word for address 0 with core_ready low.
  task automatic test_wait_states;
    do_reset();
    tick();
    for (int i = 0; i < 4; i++) begin
      total++; if (bus.mem_req !== 1'b1 || bus.pointer !== 32'h0) begin bad++; $display("FAIL wait_req[%0d]: req=%b ptr=%h want 1/0", i, bus.mem_req, bus.pointer); end
      bus.mem_ack  = (i == 3);
      bus.instr_in = (i == 3) ? mem_word(32'h0) : $urandom;
      tick();
    end
    bus.mem_ack = 1'b0;
    total++; if (bus.instr_valid !== 1'b1) begin bad++; $display("FAIL wait_valid: got %b want 1", bus.instr_valid); end
    total++; if (bus.instr_out !== mem_word(32'h0)) begin bad++; $display("FAIL wait_data: got %h want %h", bus.instr_out, mem_word(32'h0)); end
    $display("wait-state fetch addr=0 word=%h", bus.instr_out);
  endtask

  task automatic test_stall;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (bus.instr_valid !== 1'b1 || bus.mem_req !== 1'b0) begin bad++; $display("FAIL stall_hold[%0d]: valid=%b req=%b want 1/0", i, bus.instr_valid, bus.mem_req); end
      total++; if (bus.instr_out !== mem_word(32'h0)) begin bad++; $display("FAIL stall_data[%0d]: got %h want %h", i, bus.instr_out, mem_word(32'h0)); end
    end
    bus.core_ready = 1'b1;
    tick();
    bus.core_ready = 1'b0;
    total++; if (bus.mem_req !== 1'b1 || bus.pointer !== 32'h4) begin bad++; $display("FAIL stall_next: req=%b ptr=%h want 1/4", bus.mem_req, bus.pointer); end
    $display("stall released, next addr=%h", bus.pointer);
  endtask

  task automatic test_redirect_issue;
    bus.mem_ack  = 1'b1;
    bus.instr_in = mem_word(32'h4);
    tick();
    bus.mem_ack        = 1'b0;
    bus.core_ready     = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_addr  = 32'h103;
    tick();
    bus.redirect_valid = 1'b0;
    total++; if (bus.instr_valid !== 1'b0 || bus.mem_req !== 1'b1) begin bad++; $display("FAIL redir_issue_state: valid=%b req=%b want 0/1", bus.instr_valid, bus.mem_req); end
    total++; if (bus.pointer !== 32'h100) begin bad++; $display("FAIL redir_issue_ptr: got %h want %h", bus.pointer, 32'h100); end
    bus.mem_ack  = 1'b1;
    bus.instr_in = mem_word(32'h100);
    tick();
    bus.mem_ack = 1'b0;
    total++; if (bus.instr_out !== mem_word(32'h100)) begin bad++; $display("FAIL redir_issue_data: got %h want %h", bus.instr_out, mem_word(32'h100)); end
    $display("redirect in ISSUE -> addr=%h", bus.pointer);
  endtask

  task automatic test_redirect_wait;
    tick();
    total++; if (bus.pointer !== 32'h104 || bus.mem_req !== 1'b1) begin bad++; $display("FAIL redir_wait_start: ptr=%h req=%b want 104/1", bus.pointer, bus.mem_req); end
    for (int i = 0; i < 3; i++) begin
      bus.redirect_valid = (i == 0);
      bus.redirect_addr  = 32'h200;
      bus.mem_ack        = (i == 2);
      bus.instr_in       = 32'hBAD0_BAD0;
      tick();
      bus.redirect_valid = 1'b0;
      if (i < 2) begin
        total++; if (bus.pointer !== 32'h104 || bus.mem_req !== 1'b1) begin bad++; $display("FAIL redir_wait_hold[%0d]: ptr=%h req=%b want 104/1", i, bus.pointer, bus.mem_req); end
      end
    end
    bus.mem_ack = 1'b0;
    total++; if (bus.instr_valid !== 1'b0 || bus.mem_req !== 1'b1 || bus.pointer !== 32'h200) begin bad++; $display("FAIL redir_wait_reissue: valid=%b req=%b ptr=%h want 0/1/200", bus.instr_valid, bus.mem_req, bus.pointer); end
    bus.mem_ack  = 1'b1;
    bus.instr_in = mem_word(32'h200);
    tick();
    bus.mem_ack = 1'b0;
    total++; if (bus.instr_valid !== 1'b1 || bus.instr_out !== mem_word(32'h200)) begin bad++; $display("FAIL redir_wait_data: valid=%b got %h want %h", bus.instr_valid, bus.instr_out, mem_word(32'h200)); end
    $display("redirect during wait -> addr=200 word=%h", bus.instr_out);
  endtask

  task automatic test_wrap_halt;
    bus.redirect_valid = 1'b1;
    bus.redirect_addr  = 32'hFFFF_FFFC;
    tick();
    bus.redirect_valid = 1'b0;
    total++; if (bus.pointer !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_ptr: got %h want FFFFFFFC", bus.pointer); end
    bus.mem_ack  = 1'b1;
    bus.instr_in = mem_word(32'hFFFF_FFFC);
    tick();
    bus.mem_ack    = 1'b0;
    bus.core_ready = 1'b1;
    bus.halt       = 1'b1;
    tick();
    bus.halt = 1'b0;
    total++; if (bus.pointer !== 32'h0) begin bad++; $display("FAIL wrap_to_zero: got %h want 0", bus.pointer); end
    for (int i = 0; i < 3; i++) begin
      total++; if (bus.mem_req !== 1'b0 || bus.instr_valid !== 1'b0) begin bad++; $display("FAIL halted[%0d]: req=%b valid=%b want 0/0", i, bus.mem_req, bus.instr_valid); end
      tick();
    end
    bus.redirect_valid = 1'b1;
    bus.redirect_addr  = 32'h40;
    tick();
    bus.redirect_valid = 1'b0;
    total++; if (bus.mem_req !== 1'b1 || bus.pointer !== 32'h40) begin bad++; $display("FAIL halt_resume: req=%b ptr=%h want 1/40", bus.mem_req, bus.pointer); end
    $display("wrap+halt resumed at addr=%h", bus.pointer);
  endtask

  task automatic test_timeout;
    do_reset();
    tick();
`ifdef FETCH_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      total++; if (bus.mem_req !== 1'b1 || bus.fetch_err !== 1'b0) begin bad++; $display("FAIL timeout_wait[%0d]: req=%b err=%b want 1/0", i, bus.mem_req, bus.fetch_err); end
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      total++; if (bus.mem_req !== 1'b0 || bus.fetch_err !== 1'b1) begin bad++; $display("FAIL timeout_err[%0d]: req=%b err=%b want 0/1", i, bus.mem_req, bus.fetch_err); end
      tick();
    end
    bus.redirect_valid = 1'b1;
    bus.redirect_addr  = 32'h300;
    tick();
    bus.redirect_valid = 1'b0;
    total++; if (bus.fetch_err !== 1'b0 || bus.mem_req !== 1'b1 || bus.pointer !== 32'h300) begin bad++; $display("FAIL timeout_resume: err=%b req=%b ptr=%h want 0/1/300", bus.fetch_err, bus.mem_req, bus.pointer); end
`else
    for (int i = 0; i < 20; i++) begin
      total++; if (bus.mem_req !== 1'b1 || bus.fetch_err !== 1'b0) begin bad++; $display("FAIL nowait_limit[%0d]: req=%b err=%b want 1/0", i, bus.mem_req, bus.fetch_err); end
      tick();
    end
    bus.redirect_valid = 1'b1;
    bus.redirect_addr  = 32'h300;
    bus.mem_ack        = 1'b1;
    tick();
    bus.redirect_valid = 1'b0;
    bus.mem_ack        = 1'b0;
    total++; if (bus.mem_req !== 1'b1 || bus.pointer !== 32'h300) begin bad++; $display("FAIL nowait_redirect: req=%b ptr=%h want 1/300", bus.mem_req, bus.pointer); end
`endif
    bus.mem_ack  = 1'b1;
    bus.instr_in = mem_word(32'h300);
    tick();
    bus.mem_ack = 1'b0;
    total++; if (bus.instr_valid !== 1'b1 || bus.instr_out !== mem_word(32'h300)) begin bad++; $display("FAIL timeout_fetch: valid=%b got %h want %h", bus.instr_valid, bus.instr_out, mem_word(32'h300)); end
    $display("long wait recovered at addr=300");
  endtask

  // Model: the core must see instructions from exp_ptr, exp_ptr+4, ... until a redirect
  // re-targets the stream; halt after an accept stops all fetching until a redirect.
  task automatic test_random;
    logic [31:0] exp_ptr, prev_ptr, raddr;
    logic        halted, busy, prev_req, prev_ack, redir, ready, hlt;
    int          wait_left, accepts;
    exp_ptr = 32'h0; halted = 1'b0; busy = 1'b0; wait_left = 0; accepts = 0;
    prev_req = 1'b0; prev_ack = 1'b0; prev_ptr = '0;
    do_reset();
    tick();
    for (int c = 0; c < 600; c++) begin
      total++; if (bus.instr_valid && bus.mem_req) begin bad++; $display("FAIL rnd_exclusive[%0d]: valid and req both 1", c); end
      if (prev_req && !prev_ack && bus.mem_req) begin
        total++; if (bus.pointer !== prev_ptr) begin bad++; $display("FAIL rnd_ptr_stable[%0d]: got %h want %h", c, bus.pointer, prev_ptr); end
      end
      if (halted) begin
        total++; if (bus.mem_req !== 1'b0 || bus.instr_valid !== 1'b0) begin bad++; $display("FAIL rnd_halted[%0d]: req=%b valid=%b want 0/0", c, bus.mem_req, bus.instr_valid); end
      end
      if (bus.instr_valid) begin
        total++; if (bus.pointer !== exp_ptr || bus.instr_out !== mem_word(exp_ptr)) begin bad++; $display("FAIL rnd_issue[%0d]: ptr=%h word=%h want ptr=%h word=%h", c, bus.pointer, bus.instr_out, exp_ptr, mem_word(exp_ptr)); end
      end
      ready = ($urandom % 10) < 7;
      hlt   = ($urandom % 25) == 0;
      raddr = $urandom;
      if (halted) redir = ($urandom % 3) == 0;
      else if (bus.mem_req || bus.instr_valid) redir = ($urandom % 20) == 0;
      else redir = 1'b0;
      bus.core_ready = ready; bus.halt = hlt;
      bus.redirect_valid = redir; bus.redirect_addr = raddr;
      if (bus.mem_req) begin
        if (!busy) begin busy = 1'b1; wait_left = $urandom_range(0, 3); end
        if (wait_left == 0) begin
          bus.mem_ack = 1'b1; bus.instr_in = mem_word(bus.pointer); busy = 1'b0;
        end else begin
          bus.mem_ack = 1'b0; bus.instr_in = $urandom; wait_left--;
        end
      end else begin
        bus.mem_ack = 1'b0; busy = 1'b0;
      end
      if (bus.instr_valid) begin
        if (redir) exp_ptr = raddr & 32'hFFFF_FFFC;
        else if (ready) begin
          $display("rnd accept addr=%h word=%h", exp_ptr, bus.instr_out);
          accepts++;
          exp_ptr = exp_ptr + 32'd4;
          if (hlt) halted = 1'b1;
        end
      end else if (bus.mem_req) begin
        if (redir) exp_ptr = raddr & 32'hFFFF_FFFC;
      end else if (halted && redir) begin
        exp_ptr = raddr & 32'hFFFF_FFFC;
        halted  = 1'b0;
      end
      prev_req = bus.mem_req; prev_ack = bus.mem_ack; prev_ptr = bus.pointer;
      tick();
    end
    clear_inputs();
    total++; if (accepts < 30) begin bad++; $display("FAIL rnd_progress: accepts=%0d want >=30", accepts); end
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_stream();
    test_wait_states();
    test_stall();
    test_redirect_issue();
    test_redirect_wait();
    test_wrap_halt();
    test_timeout();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
